// File: rtl/axi_fifo_common_clk.sv
// Single-clock first-word-fall-through FIFO with registered status flags.
// The head word is read asynchronously from LUT RAM, so dout is valid whenever empty is low.
module axi_fifo_common_clk #(
   parameter string       C_FAMILY              = "virtex6",
   parameter int unsigned C_FIFO_DEPTH          = 256,
   parameter int unsigned C_PROG_FULL_THRESH    = 128,
   parameter int unsigned C_DATA_WIDTH          = 129,
   parameter int unsigned C_PTR_WIDTH           = 8,
   parameter int unsigned C_MEMORY_TYPE         = 1,
   parameter int unsigned C_COMMON_CLOCK        = 1,
   parameter int unsigned C_IMPLEMENTATION_TYPE = 0,
   parameter int unsigned C_SYNCHRONIZER_STAGE  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [C_DATA_WIDTH-1:0] din,
   input  logic                    wr_en,
   input  logic                    rd_en,
   output logic [C_DATA_WIDTH-1:0] dout,
   output logic                    full,
   output logic                    empty,
   output logic                    prog_full
);

   localparam logic [C_PTR_WIDTH:0] DepthCnt  = C_FIFO_DEPTH[C_PTR_WIDTH:0];
   localparam logic [C_PTR_WIDTH:0] ThreshCnt = C_PROG_FULL_THRESH[C_PTR_WIDTH:0];

   // Compatibility-only options: any value selects the same single-clock LUT-RAM FIFO.
   if (C_FAMILY == "" || C_MEMORY_TYPE > 1 || C_COMMON_CLOCK > 1 ||
       C_IMPLEMENTATION_TYPE > 0 || C_SYNCHRONIZER_STAGE > 2) begin : g_ignored_options
   end

   logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];

   logic [C_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [C_PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [C_PTR_WIDTH:0]   count_q, count_d;
   logic                   empty_q, empty_d;
   logic                   full_q, full_d;
   logic                   prog_full_q, prog_full_d;

   logic wr_acc;
   logic rd_acc;

   assign wr_acc = wr_en & ~full_q;
   assign rd_acc = rd_en & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      // Depth is a power of two, so pointer overflow is the wrap.
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      empty_d     = (count_d == '0);
      full_d      = (count_d == DepthCnt);
      prog_full_d = (count_d >= ThreshCnt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         prog_full_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         prog_full_q <= prog_full_d;
      end
   end

   // Storage is not reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= din;
      end
   end

   assign dout      = mem[rd_ptr_q];
   assign empty     = empty_q;
   assign full      = full_q;
   assign prog_full = prog_full_q;

endmodule

// File: tb/tb_axi_fifo_common_clk.sv
// Scoreboard bench for axi_fifo_common_clk: the driver queues accepted writes, a negedge
// monitor pops and compares whenever the DUT presents a word that is being read.
module tb_axi_fifo_common_clk;

   localparam int W      = 129;
   localparam int DEPTH  = 256;
   localparam int THRESH = 128;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         wr_en;
   logic         rd_en;
   logic [W-1:0] dout;
   logic         full;
   logic         empty;
   logic         prog_full;

   int           checks = 0;
   int           errors = 0;
   int           cnt    = 0;
   logic [W-1:0] exp_q[$];

   axi_fifo_common_clk #(
      .C_FAMILY              ("virtex6"),
      .C_FIFO_DEPTH          (DEPTH),
      .C_PROG_FULL_THRESH    (THRESH),
      .C_DATA_WIDTH          (W),
      .C_PTR_WIDTH           (8),
      .C_MEMORY_TYPE         (1),
      .C_COMMON_CLOCK        (1),
      .C_IMPLEMENTATION_TYPE (0),
      .C_SYNCHRONIZER_STAGE  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .dout      (dout),
      .full      (full),
      .empty     (empty),
      .prog_full (prog_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_flags(input string name, input logic e, input logic f, input logic pf);
      chk({name, "_empty"}, W'(empty), W'(e));
      chk({name, "_full"}, W'(full), W'(f));
      chk({name, "_prog_full"}, W'(prog_full), W'(pf));
   endtask

   // Monitor: a word is popped at the next posedge when rd_en is high and the FIFO is non-empty.
   always @(negedge clk) begin
      if (!rst && rd_en && !empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%0h required=none", dout);
         end else begin
            chk("pop_data", dout, exp_q.pop_front());
         end
      end
   end

   // One clock of stimulus; the scoreboard records what the FIFO must accept.
   task automatic step(input logic w, input logic r, input logic [W-1:0] d);
      bit wa;
      bit ra;
      wr_en = w;
      rd_en = r;
      din   = d;
      wa    = w && (cnt < DEPTH);
      ra    = r && (cnt > 0);
      if (wa) exp_q.push_back(d);
      @(posedge clk);
      #1;
      cnt = cnt + int'(wa) - int'(ra);
      checks++;
      if ((empty !== (cnt == 0)) || (full !== (cnt == DEPTH)) ||
          (prog_full !== (cnt >= THRESH))) begin
         errors++;
         $display("FAIL step_flags actual=e%0b f%0b p%0b required_count=%0d",
                  empty, full, prog_full, cnt);
      end
   endtask

   initial begin
      logic [W-1:0] first_word;
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_flags("reset", 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      step(1'b0, 1'b0, '0);
      chk_flags("idle_after_reset", 1'b1, 1'b0, 1'b0);

      // Single word: visible right after the write edge, gone after one pop.
      first_word = {1'b0, 128'h0AAAAAAAAAAAAAAAAAAAAAAAAAAAAA01};
      step(1'b1, 1'b0, first_word);
      chk_flags("one_word", 1'b0, 1'b0, 1'b0);
      chk("one_word_dout", dout, first_word);
      step(1'b0, 1'b1, '0);
      chk_flags("one_word_popped", 1'b1, 1'b0, 1'b0);

      // Asynchronous reset with five words stored.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(i + 100));
      chk_flags("five_words", 1'b0, 1'b0, 1'b0);
      wr_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_flags("async_reset", 1'b1, 1'b0, 1'b0);
      exp_q.delete();
      cnt = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      step(1'b0, 1'b1, '0);
      chk_flags("read_after_reset", 1'b1, 1'b0, 1'b0);

      // Fill past capacity: prog_full after write 128, full after 256, the rest dropped.
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, 1'b0, W'(i));
         if (i == 127) chk_flags("fill_127", 1'b0, 1'b0, 1'b0);
         if (i == 128) chk_flags("fill_128", 1'b0, 1'b0, 1'b1);
         if (i == 255) chk_flags("fill_255", 1'b0, 1'b0, 1'b1);
         if (i == 256) chk_flags("fill_256", 1'b0, 1'b1, 1'b1);
      end
      chk_flags("fill_300", 1'b0, 1'b1, 1'b1);
      chk("full_head", dout, W'(1));
      for (int i = 0; i < 256; i++) step(1'b0, 1'b1, '0);
      chk_flags("drained", 1'b1, 1'b0, 1'b0);
      chk("drained_queue", W'(exp_q.size()), W'(0));

      // Streaming 1000 words with rd_en following non-empty; pointers wrap several times.
      for (int i = 0; i < 1000; i++) step(1'b1, cnt > 0, W'(i + 5000));
      step(1'b0, 1'b1, '0);
      chk_flags("stream_done", 1'b1, 1'b0, 1'b0);

      // Simultaneous read and write while full: read wins, write dropped.
      for (int i = 1; i <= 256; i++) step(1'b1, 1'b0, W'(i));
      chk_flags("refill", 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, W'(32'hDEAD));
      chk_flags("full_rw", 1'b0, 1'b0, 1'b1);
      chk("full_rw_head", dout, W'(2));
      for (int i = 0; i < 255; i++) step(1'b0, 1'b1, '0);
      chk_flags("full_rw_drained", 1'b1, 1'b0, 1'b0);

      // Simultaneous read and write while empty: write wins, read ignored.
      step(1'b1, 1'b1, W'(8'h55));
      chk_flags("empty_rw", 1'b0, 1'b0, 1'b0);
      chk("empty_rw_dout", dout, W'(8'h55));
      step(1'b0, 1'b1, '0);
      chk_flags("empty_rw_drained", 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0);
      chk("final_queue", W'(exp_q.size()), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
